cfg_bus_master: RTL and testbench

//  Initiator side of the peripheral cfg bus (cfg_sel/wr/addr/wdata/rdata). It accepts

---
 rtl/cfg_bus_pkg.sv | 18 +
 rtl/cfg_req_fifo.sv | 39 +++
 rtl/cfg_bus_master.sv | 81 ++++++++
 tb/tb_cfg_bus_master.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cfg_bus_pkg.sv
// cfg_bus_pkg: shared types, address window defaults and peripheral register offsets for the cfg bus
package cfg_bus_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cfg_req_t;
  localparam logic [31:0] DEF_ADDR_BASE = 32'h1000_0000;
  localparam logic [31:0] DEF_ADDR_MASK = 32'h0000_00FF;
  localparam logic [7:0] REG_CFG    = 8'h10;
  localparam logic [7:0] REG_RELOAD = 8'h14;
  localparam logic [7:0] REG_COUNT  = 8'h18;
  localparam logic [7:0] REG_STATUS = 8'h1C;
  function automatic logic req_legal(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] mask);
    return addr[1:0] == 2'b00 && (addr & ~mask) == base;
  endfunction
endpackage

// File: rtl/cfg_req_fifo.sv
// cfg_req_fifo: synchronous request FIFO of DEPTH cfg_req_t entries
//   clk_i, reset_n_i : clock, async active-low reset
//   push, din        : write side (accepted when not full, or when full with a same-cycle pop)
//   pop, dout        : read side, dout shows the head entry
//   full, empty      : occupancy flags
module cfg_req_fifo
  import cfg_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     reset_n_i,
  input  logic     push,
  input  cfg_req_t din,
  input  logic     pop,
  output cfg_req_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  cfg_req_t mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty   = wp == rp;
  assign full    = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp[AW-1:0]];
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk_i)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/cfg_bus_master.sv
// cfg_bus_master: queues core requests and runs one single-cycle cfg bus access per request
//   req_*  : core request port (valid/ready, wr, addr, wdata)
//   resp_* : response port (valid/ready, rdata, err)
//   cfg_*  : cfg bus initiator (sel, wr, addr, wdata out; rdata in)
module cfg_bus_master
  import cfg_bus_pkg::*;
#(
  parameter int          REQ_DEPTH = 2,
  parameter logic [31:0] ADDR_BASE = DEF_ADDR_BASE,
  parameter logic [31:0] ADDR_MASK = DEF_ADDR_MASK
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        cfg_sel_o,
  output logic        cfg_wr_o,
  output logic [31:0] cfg_addr_o,
  output logic [31:0] cfg_wdata_o,
  input  logic [31:0] cfg_rdata_i
);
  state_t state, state_n;
  cfg_req_t head;
  logic full, empty, pop, head_ok, wr_q, err_q;
  logic [31:0] rdata_q;
  cfg_req_fifo #(.DEPTH(REQ_DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .push     (req_valid_i && req_ready_o),
    .din      ({req_wr_i, req_addr_i, req_wdata_i}),
    .pop      (pop),
    .dout     (head),
    .full     (full),
    .empty    (empty)
  );
  assign req_ready_o  = !full;
  assign head_ok      = req_legal(head.addr, ADDR_BASE, ADDR_MASK);
  assign cfg_sel_o    = state == ACCESS;
  assign cfg_wr_o     = cfg_sel_o && wr_q;
  assign resp_valid_o = state == RESP;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  // The next request is popped either from IDLE or in the same cycle the current response is taken.
  always_comb begin
    pop     = !empty && (state == IDLE || (state == RESP && resp_ready_i));
    state_n = pop ? (head_ok ? ACCESS : RESP) :
              state == ACCESS ? RESP :
              state == RESP && resp_ready_i ? IDLE : state;
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state       <= IDLE;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      cfg_addr_o  <= '0;
      cfg_wdata_o <= '0;
    end else begin
      state <= state_n;
      if (pop && head_ok) begin
        wr_q        <= head.wr;
        cfg_addr_o  <= head.addr;
        cfg_wdata_o <= head.wdata;
      end
      if (pop && !head_ok) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
      if (state == ACCESS) begin
        rdata_q <= wr_q ? '0 : cfg_rdata_i;
        err_q   <= 1'b0;
      end
    end
endmodule

// File: tb/tb_cfg_bus_master.sv
// tb_cfg_bus_master: directed bench for cfg_bus_master against a small timer register responder
module tb_cfg_bus_master;
  import cfg_bus_pkg::*;
  logic        clk_i = 1'b0, reset_n_i = 1'b0;
  logic        req_valid_i = 1'b0, req_ready_o, req_wr_i = 1'b0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic        resp_valid_o, resp_ready_i = 1'b1, resp_err_o;
  logic [31:0] resp_rdata_o;
  logic        cfg_sel_o, cfg_wr_o;
  logic [31:0] cfg_addr_o, cfg_wdata_o, cfg_rdata_i;
  int tests = 0, fails = 0;
  localparam logic [31:0] COUNT_VAL = 32'd41;
  logic [31:0] m_cfg = '0, m_reload = 32'd50, m_status = 32'h5A;
  cfg_bus_master dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .cfg_sel_o(cfg_sel_o), .cfg_wr_o(cfg_wr_o), .cfg_addr_o(cfg_addr_o),
    .cfg_wdata_o(cfg_wdata_o), .cfg_rdata_i(cfg_rdata_i)
  );
  always #5 clk_i = ~clk_i;
  assign cfg_rdata_i = cfg_addr_o[7:0] == REG_CFG    ? m_cfg :
                       cfg_addr_o[7:0] == REG_RELOAD ? m_reload :
                       cfg_addr_o[7:0] == REG_COUNT  ? COUNT_VAL :
                       cfg_addr_o[7:0] == REG_STATUS ? m_status : 32'hDEAD_BEEF;
  always @(posedge clk_i)
    if (cfg_sel_o && cfg_wr_o)
      case (cfg_addr_o[7:0])
        REG_CFG:    m_cfg <= cfg_wdata_o;
        REG_RELOAD: m_reload <= cfg_wdata_o;
        REG_STATUS: m_status <= cfg_wdata_o;
        default: ;
      endcase
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sel"}, 32'(cfg_sel_o), 0);
    chk({tag, "_wr"}, 32'(cfg_wr_o), 0);
    chk({tag, "_addr"}, cfg_addr_o, 0);
    chk({tag, "_wdata"}, cfg_wdata_o, 0);
    chk({tag, "_rvalid"}, 32'(resp_valid_o), 0);
    chk({tag, "_rdata"}, resp_rdata_o, 0);
    chk({tag, "_err"}, 32'(resp_err_o), 0);
    chk({tag, "_ready"}, 32'(req_ready_o), 1);
  endtask
  // Single request into an idle master: checks strobe count, bus fields, latency and response.
  task automatic run(input string tag, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic exp_err, input logic [31:0] exp_rdata);
    int n = 0, sels = 0;
    logic s_wr = 1'b0;
    logic [31:0] s_addr = '0, s_wdata = '0;
    resp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_wr_i = wr; req_addr_i = addr; req_wdata_i = wdata;
    chk({tag, "_ready"}, 32'(req_ready_o), 1);
    tick();
    req_valid_i = 1'b0;
    while (!resp_valid_o && n < 8) begin
      if (cfg_sel_o) begin
        sels++; s_wr = cfg_wr_o; s_addr = cfg_addr_o; s_wdata = cfg_wdata_o;
      end
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, exp_err ? 1 : 2);
    chk({tag, "_sel_pulses"}, sels, exp_err ? 0 : 1);
    if (!exp_err) begin
      chk({tag, "_cfg_wr"}, 32'(s_wr), 32'(wr));
      chk({tag, "_cfg_addr"}, s_addr, addr);
      if (wr) chk({tag, "_cfg_wdata"}, s_wdata, wdata);
    end
    chk({tag, "_rvalid"}, 32'(resp_valid_o), 1);
    chk({tag, "_sel_in_resp"}, 32'(cfg_sel_o), 0);
    chk({tag, "_err"}, 32'(resp_err_o), 32'(exp_err));
    chk({tag, "_rdata"}, resp_rdata_o, exp_rdata);
    tick();
    chk({tag, "_rvalid_after_accept"}, 32'(resp_valid_o), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [32:0] rsp [3];
    int got;
    repeat (2) @(posedge clk_i);
    #1;
    chk_idle_outputs("reset");
    reset_n_i = 1'b1;
    tick();
    run("t1_write_cfg", 1'b1, 32'h1000_0010, 32'h3, 1'b0, 32'h0);
    chk("t1_cfg_commit", m_cfg, 32'h3);
    run("t2_read_reload", 1'b0, 32'h1000_0014, 32'h0, 1'b0, 32'h32);
    run("t3_misaligned", 1'b0, 32'h1000_0013, 32'h0, 1'b1, 32'h0);
    run("t4_out_of_window", 1'b1, 32'h2000_0010, 32'h1234, 1'b1, 32'h0);
    run("t4_read_count", 1'b0, 32'h1000_0018, 32'h0, 1'b0, COUNT_VAL);
    chk("t1_cfg_readback_after", m_cfg, 32'h3);
    resp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_wr_i = 1'b0; req_addr_i = 32'h1000_0010;
    chk("t5_ready_a", 32'(req_ready_o), 1);
    tick();
    req_addr_i = 32'h1000_0014;
    chk("t5_ready_b", 32'(req_ready_o), 1);
    tick();
    req_addr_i = 32'h1000_0101;
    chk("t5_ready_c", 32'(req_ready_o), 1);
    tick();
    req_addr_i = 32'h1000_001C;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t5_stall%0d_ready", i), 32'(req_ready_o), 0);
      chk($sformatf("t5_stall%0d_rvalid", i), 32'(resp_valid_o), 1);
      chk($sformatf("t5_stall%0d_rdata", i), resp_rdata_o, 32'h3);
      chk($sformatf("t5_stall%0d_err", i), 32'(resp_err_o), 0);
      tick();
    end
    resp_ready_i = 1'b1;
    tick();
    chk("t5_ready_after_accept", 32'(req_ready_o), 1);
    chk("t5_rvalid_in_access", 32'(resp_valid_o), 0);
    tick();
    req_valid_i = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && got < 3; i++) begin
      if (resp_valid_o) begin
        rsp[got] = {resp_err_o, resp_rdata_o};
        got++;
      end
      tick();
    end
    chk("t5_resp_count", got, 3);
    chk("t5_resp_b", {31'b0, rsp[0][32]} ^ rsp[0][31:0], 32'h32);
    chk("t5_resp_b_err", 32'(rsp[0][32]), 0);
    chk("t5_resp_c_err", 32'(rsp[1][32]), 1);
    chk("t5_resp_c_rdata", rsp[1][31:0], 32'h0);
    chk("t5_resp_d", rsp[2][31:0], 32'h5A);
    chk("t5_resp_d_err", 32'(rsp[2][32]), 0);
    req_valid_i = 1'b1; req_wr_i = 1'b1; req_addr_i = 32'h1000_001C; req_wdata_i = 32'h77;
    tick();
    req_addr_i = 32'h1000_0010; req_wdata_i = 32'h99;
    tick();
    req_valid_i = 1'b0;
    chk("t6_in_access_sel", 32'(cfg_sel_o), 1);
    chk("t6_in_access_wr", 32'(cfg_wr_o), 1);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk_idle_outputs("t6_reset");
    repeat (2) @(posedge clk_i);
    #1;
    chk("t6_no_status_write", m_status, 32'h5A);
    chk("t6_no_cfg_write", m_cfg, 32'h3);
    reset_n_i = 1'b1;
    chk("t6_ready_after_release", 32'(req_ready_o), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t6_flushed%0d_sel", i), 32'(cfg_sel_o), 0);
      chk($sformatf("t6_flushed%0d_rvalid", i), 32'(resp_valid_o), 0);
    end
    chk("t6_status_final", m_status, 32'h5A);
    run("t6_after_reset_read", 1'b0, 32'h1000_0014, 32'h0, 1'b0, 32'h32);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
